// File: rtl/demux1to8_32_pkg.sv
// -----------------------------------------------------------------------------
// demux1to8_32_pkg
// Shared constants and helpers for the registered 1-to-8 word distributor.
//   DEMUX_NCH       number of output channels
//   DEMUX_SELW      width of the channel select
//   DEMUX_WIDTH     data width of every channel
//   DEMUX_RST_DATA  value loaded into every holding register on reset
//   demux_onehot()  3-bit select -> 8-bit one-hot channel mask
// -----------------------------------------------------------------------------
package demux1to8_32_pkg;

    localparam int DEMUX_NCH   = 8;
    localparam int DEMUX_SELW  = 3;
    localparam int DEMUX_WIDTH = 32;

    localparam logic [DEMUX_WIDTH-1:0] DEMUX_RST_DATA = 32'h0000_0000;

    // Channel select decode; an unknown select maps to "no channel".
    function automatic logic [DEMUX_NCH-1:0] demux_onehot(input logic [DEMUX_SELW-1:0] sel);
        logic [DEMUX_NCH-1:0] oh;
        case (sel)
            3'd0:    oh = 8'b0000_0001;
            3'd1:    oh = 8'b0000_0010;
            3'd2:    oh = 8'b0000_0100;
            3'd3:    oh = 8'b0000_1000;
            3'd4:    oh = 8'b0001_0000;
            3'd5:    oh = 8'b0010_0000;
            3'd6:    oh = 8'b0100_0000;
            3'd7:    oh = 8'b1000_0000;
            default: oh = 8'b0000_0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry holding register with valid bit for a single output channel.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears data and valid)
//   load   write din into the slot and mark it valid
//   drain  consumer takes the current word this cycle
//   flush  synchronous clear of the valid bit (data is kept)
//   din    word to store
//   dout   stored word
//   valid  slot holds a word not yet taken by the consumer
// -----------------------------------------------------------------------------
module demux_slot
    import demux1to8_32_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Holding register and valid bit; a load wins over a same-cycle drain so
    // a channel streams one word per cycle when its consumer is always ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= WIDTH'(DEMUX_RST_DATA);
            valid_r <= 1'b0;
        end else if (flush) begin
            data_r  <= data_r;
            valid_r <= 1'b0;
        end else begin
            if (load) begin
                data_r <= din;
            end else begin
                data_r <= data_r;
            end
            valid_r <= load | (valid_r & ~drain);
        end
    end

    assign dout  = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/demux1to8_32.sv
// -----------------------------------------------------------------------------
// demux1to8_32
// Registered 1-to-8 distributor: routes a 32-bit word to one of eight
// per-channel holding registers, each with its own valid/ready handshake.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   Di/SEL/Vi  producer word, destination channel and valid
//   Ri         producer ready (combinational from SEL, Vo, Ro, Flush)
//   Flush      synchronous clear of every channel valid
//   Do0..Do7   registered channel data
//   Vo / Ro    per-channel valid / consumer ready
//   Busy       any channel holds a word
// -----------------------------------------------------------------------------
module demux1to8_32
    import demux1to8_32_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int NCH   = DEMUX_NCH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      Di,
    input  logic [DEMUX_SELW-1:0] SEL,
    input  logic                  Vi,
    output logic                  Ri,
    input  logic                  Flush,
    output logic [WIDTH-1:0]      Do0,
    output logic [WIDTH-1:0]      Do1,
    output logic [WIDTH-1:0]      Do2,
    output logic [WIDTH-1:0]      Do3,
    output logic [WIDTH-1:0]      Do4,
    output logic [WIDTH-1:0]      Do5,
    output logic [WIDTH-1:0]      Do6,
    output logic [WIDTH-1:0]      Do7,
    output logic [NCH-1:0]        Vo,
    input  logic [NCH-1:0]        Ro,
    output logic                  Busy
);

    logic [NCH-1:0]   sel_oh_s;
    logic [NCH-1:0]   load_s;
    logic [NCH-1:0]   drain_s;
    logic [NCH-1:0]   vo_s;
    logic             ri_s;
    logic             accept_s;
    logic [WIDTH-1:0] dout_s [NCH];

    // Ready: the selected slot is empty or is being drained this cycle, and
    // no flush is pending (a flush cycle never accepts).
    always_comb begin
        sel_oh_s = demux_onehot(SEL);
        ri_s     = 1'b0;
        if (Flush) begin
            ri_s = 1'b0;
        end else begin
            ri_s = !vo_s[SEL] || Ro[SEL];
        end
        accept_s = Vi && ri_s;
        drain_s  = vo_s & Ro;
        if (accept_s) begin
            load_s = sel_oh_s;
        end else begin
            load_s = {NCH{1'b0}};
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_s[k]),
            .drain (drain_s[k]),
            .flush (Flush),
            .din   (Di),
            .dout  (dout_s[k]),
            .valid (vo_s[k])
        );
    end

    assign Ri   = ri_s;
    assign Vo   = vo_s;
    assign Busy = |vo_s;
    assign Do0  = dout_s[0];
    assign Do1  = dout_s[1];
    assign Do2  = dout_s[2];
    assign Do3  = dout_s[3];
    assign Do4  = dout_s[4];
    assign Do5  = dout_s[5];
    assign Do6  = dout_s[6];
    assign Do7  = dout_s[7];

endmodule

// File: tb/tb_demux1to8_32.sv
module tb_demux1to8_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Di;
    logic [2:0]  SEL;
    logic        Vi;
    logic        Ri;
    logic        Flush;
    logic [31:0] Do0, Do1, Do2, Do3, Do4, Do5, Do6, Do7;
    logic [7:0]  Vo;
    logic [7:0]  Ro;
    logic        Busy;

    always #5 clk = ~clk;

    demux1to8_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Di    (Di),
        .SEL   (SEL),
        .Vi    (Vi),
        .Ri    (Ri),
        .Flush (Flush),
        .Do0   (Do0),
        .Do1   (Do1),
        .Do2   (Do2),
        .Do3   (Do3),
        .Do4   (Do4),
        .Do5   (Do5),
        .Do6   (Do6),
        .Do7   (Do7),
        .Vo    (Vo),
        .Ro    (Ro),
        .Busy  (Busy)
    );

    logic [31:0] do_s [8];
    assign do_s[0] = Do0;
    assign do_s[1] = Do1;
    assign do_s[2] = Do2;
    assign do_s[3] = Do3;
    assign do_s[4] = Do4;
    assign do_s[5] = Do5;
    assign do_s[6] = Do6;
    assign do_s[7] = Do7;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: eight mailboxes, each holding a word and a full flag.
    logic [31:0] m_data  [8];
    bit          m_full  [8];

    typedef struct {
        logic        vi;
        logic [2:0]  sel;
        logic [31:0] di;
        logic [7:0]  ro;
        logic        flush;
        logic        exp_ri;
        logic [7:0]  exp_vo;
        logic [31:0] exp_do;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic vi, logic [2:0] sel, logic [31:0] di, logic [7:0] ro,
                                logic flush, logic exp_ri, logic [7:0] exp_vo, logic [31:0] exp_do);
        vec_t v;
        v.vi = vi; v.sel = sel; v.di = di; v.ro = ro; v.flush = flush;
        v.exp_ri = exp_ri; v.exp_vo = exp_vo; v.exp_do = exp_do;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] model_vo();
        logic [7:0] v = 8'h00;
        for (int k = 0; k < 8; k++) if (m_full[k]) v = v | (8'h01 << k);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_data[k] = 32'h0;
            m_full[k] = 1'b0;
        end
    endtask

    task automatic check_model(string tag);
        check({tag, " Vo"}, {24'h0, Vo}, {24'h0, model_vo()});
        check({tag, " Busy"}, {31'h0, Busy}, {31'h0, model_vo() != 8'h00});
        for (int k = 0; k < 8; k++) check($sformatf("%s Do%0d", tag, k), do_s[k], m_data[k]);
    endtask

    // One clock: drive at negedge, check Ri before the edge, then outputs after it.
    task automatic cycle(input logic vi, input logic [2:0] sel, input logic [31:0] di,
                         input logic [7:0] ro, input logic flush, input string tag,
                         output logic ri_obs);
        logic ri_exp;
        @(negedge clk);
        Vi = vi; SEL = sel; Di = di; Ro = ro; Flush = flush;
        #1;
        ri_exp = !flush && (!m_full[sel] || ro[sel]);
        ri_obs = Ri;
        check({tag, " Ri"}, {31'h0, Ri}, {31'h0, ri_exp});
        @(posedge clk);
        #1;
        if (flush) begin
            for (int k = 0; k < 8; k++) m_full[k] = 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) if (m_full[k] && ro[k]) m_full[k] = 1'b0;
            if (vi && ri_exp) begin
                m_data[sel] = di;
                m_full[sel] = 1'b1;
            end
        end
        check_model(tag);
    endtask

    initial begin
        logic        ri_o;
        logic        hold;
        logic [2:0]  r_sel;
        logic [31:0] r_di;

        rst_n = 1'b0; Vi = 1'b0; SEL = 3'd0; Di = 32'h0; Ro = 8'h00; Flush = 1'b0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset Ri", {31'h0, Ri}, 32'h1);

        // Randomized traffic; a stalled request keeps SEL/Di stable.
        hold = 1'b0; r_sel = 3'd0; r_di = 32'h0;
        for (int i = 0; i < 300; i++) begin
            logic vi_r;
            if (!hold) begin
                r_sel = 3'($urandom_range(0, 7));
                r_di  = $urandom;
                vi_r  = ($urandom_range(0, 3) != 0);
            end else begin
                vi_r = 1'b1;
            end
            cycle(vi_r, r_sel, r_di, 8'($urandom), ($urandom_range(0, 19) == 0), "rand", ri_o);
            hold = vi_r && !ri_o;
        end

        // Asynchronous reset in the middle of a cycle with channels full.
        cycle(1'b1, 3'd4, 32'h1234_5678, 8'h00, 1'b0, "pre-rst", ri_o);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async rst");
        Vi = 1'b0; Flush = 1'b0; SEL = 3'd0; Ro = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst release Ri", {31'h0, Ri}, 32'h1);

        // Directed vectors; expected values worked out by hand.
        tbl.push_back(mk(1'b1, 3'd5, 32'hDEADBEEF, 8'h00, 1'b0, 1'b1, 8'h20, 32'hDEADBEEF));
        tbl.push_back(mk(1'b1, 3'd5, 32'h1111_1111, 8'h00, 1'b0, 1'b0, 8'h20, 32'hDEADBEEF));
        tbl.push_back(mk(1'b1, 3'd2, 32'h1, 8'h04, 1'b0, 1'b1, 8'h24, 32'h1));
        tbl.push_back(mk(1'b1, 3'd2, 32'h2, 8'h04, 1'b0, 1'b1, 8'h24, 32'h2));
        tbl.push_back(mk(1'b1, 3'd2, 32'h3, 8'h04, 1'b0, 1'b1, 8'h24, 32'h3));
        tbl.push_back(mk(1'b0, 3'd0, 32'h0, 8'h24, 1'b0, 1'b1, 8'h00, 32'h0));
        tbl.push_back(mk(1'b1, 3'd0, 32'hAA, 8'h00, 1'b0, 1'b1, 8'h01, 32'hAA));
        tbl.push_back(mk(1'b1, 3'd0, 32'hBB, 8'h00, 1'b0, 1'b0, 8'h01, 32'hAA));
        tbl.push_back(mk(1'b1, 3'd7, 32'h77, 8'h00, 1'b0, 1'b1, 8'h81, 32'h77));
        tbl.push_back(mk(1'b0, 3'd0, 32'h0, 8'h01, 1'b0, 1'b1, 8'h80, 32'hAA));
        tbl.push_back(mk(1'b1, 3'd0, 32'h100, 8'h00, 1'b0, 1'b1, 8'h81, 32'h100));
        tbl.push_back(mk(1'b1, 3'd1, 32'h101, 8'h00, 1'b0, 1'b1, 8'h83, 32'h101));
        tbl.push_back(mk(1'b1, 3'd2, 32'h102, 8'h00, 1'b0, 1'b1, 8'h87, 32'h102));
        tbl.push_back(mk(1'b1, 3'd3, 32'h103, 8'h00, 1'b0, 1'b1, 8'h8F, 32'h103));
        tbl.push_back(mk(1'b1, 3'd4, 32'h104, 8'h00, 1'b0, 1'b1, 8'h9F, 32'h104));
        tbl.push_back(mk(1'b1, 3'd5, 32'h105, 8'h00, 1'b0, 1'b1, 8'hBF, 32'h105));
        tbl.push_back(mk(1'b1, 3'd6, 32'h106, 8'h00, 1'b0, 1'b1, 8'hFF, 32'h106));
        tbl.push_back(mk(1'b1, 3'd3, 32'hCAFE, 8'h00, 1'b1, 1'b0, 8'h00, 32'h103));
        tbl.push_back(mk(1'b0, 3'd0, 32'h0, 8'h00, 1'b0, 1'b1, 8'h00, 32'h100));
        for (int k = 0; k < 8; k++) begin
            logic [31:0] w;
            w = 32'(k) * 32'h1111_1111;
            tbl.push_back(mk(1'b1, 3'(k), w, 8'hFF, 1'b0, 1'b1, 8'h01 << k, w));
        end
        tbl.push_back(mk(1'b0, 3'd7, 32'h0, 8'hFF, 1'b0, 1'b1, 8'h00, 32'h7777_7777));

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cycle(tbl[i].vi, tbl[i].sel, tbl[i].di, tbl[i].ro, tbl[i].flush, t, ri_o);
            check({t, " tbl Ri"}, {31'h0, ri_o}, {31'h0, tbl[i].exp_ri});
            check({t, " tbl Vo"}, {24'h0, Vo}, {24'h0, tbl[i].exp_vo});
            check({t, " tbl Do"}, do_s[tbl[i].sel], tbl[i].exp_do);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
